// File: rtl/instr_fetch.sv
// Fetch stage plus IF/ID register: one outstanding imem read, a one-entry skid
// buffer for words decode cannot take, and delay-slot-aware redirect handling.
module instr_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] pc,
  output logic [31:0] instr,
  output logic        instr_valid,
  input  logic        stall,
  input  logic        jump_branch,
  input  logic        jump_target,
  input  logic        jump_reg,
  input  logic [31:0] jr_pc
);

  localparam int unsigned XLEN = 32;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_WAIT
  } state_e;

  state_e            state_q, state_d;
  logic              imem_req_q, imem_req_d;
  logic [XLEN-1:0]   imem_addr_q, imem_addr_d;
  logic [XLEN-1:0]   fetch_pc_q, fetch_pc_d;
  logic [XLEN-1:0]   skid_instr_q, skid_instr_d;
  logic [XLEN-1:0]   skid_pc_q, skid_pc_d;
  logic [XLEN-1:0]   pc_q, pc_d;
  logic [XLEN-1:0]   instr_q, instr_d;
  logic              instr_valid_q, instr_valid_d;

  logic [XLEN-1:0]   p4_c;
  logic [XLEN-1:0]   br_off_c;
  logic [XLEN-1:0]   target_c;
  logic [XLEN-1:0]   next_addr_c;
  logic              redirect_c;
  logic              issue_c;

  // Redirect target from the instruction currently in IF/ID
  always_comb begin
    p4_c     = pc_q + XLEN'(4);
    br_off_c = {{14{instr_q[15]}}, instr_q[15:0], 2'b00};
    if (jump_reg) begin
      target_c = {jr_pc[31:2], 2'b00};
    end else if (jump_target) begin
      target_c = {p4_c[31:28], instr_q[25:0], 2'b00};
    end else begin
      target_c = p4_c + br_off_c;
    end
    redirect_c  = instr_valid_q & ~stall & (jump_branch | jump_target | jump_reg);
    next_addr_c = redirect_c ? target_c : fetch_pc_q;
  end

  // The word after the branch is always already issued (in flight, in SKID, or
  // landing in IF/ID this edge), so the target only ever replaces fetch_pc.
  always_comb begin
    state_d       = state_q;
    imem_req_d    = imem_req_q;
    imem_addr_d   = imem_addr_q;
    fetch_pc_d    = fetch_pc_q;
    skid_instr_d  = skid_instr_q;
    skid_pc_d     = skid_pc_q;
    pc_d          = pc_q;
    instr_d       = instr_q;
    instr_valid_d = instr_valid_q;
    issue_c       = 1'b0;

    if (!stall) begin
      instr_d       = '0;
      instr_valid_d = 1'b0;
    end

    case (state_q)
      ST_IDLE: begin
        issue_c = 1'b1;
        state_d = ST_REQ;
      end
      ST_REQ: begin
        if (imem_ack) begin
          if (stall) begin
            skid_instr_d = imem_rdata;
            skid_pc_d    = imem_addr_q;
            imem_req_d   = 1'b0;
            state_d      = ST_WAIT;
          end else begin
            pc_d          = imem_addr_q;
            instr_d       = imem_rdata;
            instr_valid_d = 1'b1;
            issue_c       = 1'b1;
          end
        end
      end
      ST_WAIT: begin
        if (!stall) begin
          pc_d          = skid_pc_q;
          instr_d       = skid_instr_q;
          instr_valid_d = 1'b1;
          issue_c       = 1'b1;
          state_d       = ST_REQ;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (issue_c) begin
      imem_req_d  = 1'b1;
      imem_addr_d = next_addr_c;
      fetch_pc_d  = next_addr_c + XLEN'(4);
    end else if (redirect_c) begin
      fetch_pc_d = target_c;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      imem_req_q    <= 1'b0;
      imem_addr_q   <= '0;
      fetch_pc_q    <= {RESET_PC[31:2], 2'b00};
      skid_instr_q  <= '0;
      skid_pc_q     <= '0;
      pc_q          <= '0;
      instr_q       <= '0;
      instr_valid_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      imem_req_q    <= imem_req_d;
      imem_addr_q   <= imem_addr_d;
      fetch_pc_q    <= fetch_pc_d;
      skid_instr_q  <= skid_instr_d;
      skid_pc_q     <= skid_pc_d;
      pc_q          <= pc_d;
      instr_q       <= instr_d;
      instr_valid_q <= instr_valid_d;
    end
  end

  assign imem_req    = imem_req_q;
  assign imem_addr   = imem_addr_q;
  assign pc          = pc_q;
  assign instr       = instr_q;
  assign instr_valid = instr_valid_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: emulated imem and decode, program-order scoreboard.
module tb_instr_fetch;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] pc;
  logic [31:0] instr;
  logic        instr_valid;
  logic        stall;
  logic        jump_branch;
  logic        jump_target;
  logic        jump_reg;
  logic [31:0] jr_pc;

  instr_fetch #(.RESET_PC(RESET_PC)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .pc(pc), .instr(instr), .instr_valid(instr_valid),
    .stall(stall), .jump_branch(jump_branch), .jump_target(jump_target),
    .jump_reg(jump_reg), .jr_pc(jr_pc)
  );

  always #5 clk = ~clk;

  typedef struct packed { logic [31:0] addr; logic [31:0] data; } word_t;
  typedef struct packed { logic [1:0] kind; logic [31:0] jr; } jmp_t;

  int checks = 0;
  int errors = 0;

  word_t       rq[$];
  logic [31:0] dlog[$];
  bit          vlog[$];
  logic [31:0] mem_ovr[logic [31:0]];
  jmp_t        jmp_at[logic [31:0]];

  logic [31:0] exp_pc;
  bit          armed;
  logic [31:0] armed_tgt;
  int          req_age;
  int          cur_lat;

  int          lat_min = 1;
  int          lat_max = 1;
  bit          stall_rand = 0;
  bit          stall_force = 0;
  bit          rand_jumps = 0;
  bit          rand_acks = 0;
  bit          force_on = 0;
  logic [31:0] force_jr;

  function automatic logic [31:0] mem_word(logic [31:0] a);
    if (mem_ovr.exists(a)) return mem_ovr[a];
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
  endfunction

  function automatic int find_pc(logic [31:0] a);
    foreach (dlog[i]) if (dlog[i] == a) return i;
    return -1;
  endfunction

  task automatic model_reset();
    rq.delete();
    jmp_at.delete();
    exp_pc   = RESET_PC;
    armed    = 0;
    req_age  = 0;
    cur_lat  = $urandom_range(lat_max, lat_min);
    force_on = 0;
  endtask

  // Decode and memory emulation for the coming edge
  task automatic drive_inputs();
    jump_branch = 0; jump_target = 0; jump_reg = 0;
    jr_pc = $urandom;
    stall = stall_force | (stall_rand && $urandom_range(0, 3) == 0);
    if (instr_valid) begin
      if (jmp_at.exists(pc)) begin
        case (jmp_at[pc].kind)
          2'd1: jump_branch = 1;
          2'd2: jump_target = 1;
          default: begin jump_reg = 1; jr_pc = jmp_at[pc].jr; end
        endcase
      end else if (force_on) begin
        jump_reg = 1; jr_pc = force_jr;
      end else if (rand_jumps && $urandom_range(0, 5) == 0) begin
        {jump_reg, jump_target, jump_branch} = 3'($urandom_range(1, 7));
      end
    end
    imem_ack = 0;
    imem_rdata = $urandom;
    if (imem_req) begin
      if (req_age + 1 >= cur_lat) begin
        imem_ack = 1; imem_rdata = mem_word(imem_addr);
      end
    end else if (rand_acks) begin
      imem_ack = 1'($urandom_range(0, 1));
    end
  endtask

  // One clock with scoreboard update: words reach decode in program order
  task automatic step();
    logic p_req, p_ack, p_stall, p_valid, p_jb, p_jt, p_jr;
    logic [31:0] p_addr, p_rdata, p_pc, p_instr, p_jrpc, p4, off, tgt;
    word_t w;
    drive_inputs();
    p_req = imem_req; p_ack = imem_ack; p_addr = imem_addr; p_rdata = imem_rdata;
    p_stall = stall; p_valid = instr_valid; p_pc = pc; p_instr = instr;
    p_jb = jump_branch; p_jt = jump_target; p_jr = jump_reg; p_jrpc = jr_pc;
    @(posedge clk); #1;
    if (p_req && p_ack) begin w.addr = p_addr; w.data = p_rdata; rq.push_back(w); end
    if (p_stall) begin
      checks++;
      if ({pc, instr, instr_valid} !== {p_pc, p_instr, p_valid}) begin
        errors++;
        $display("FAIL stall_hold: got pc=%h instr=%h v=%b expected pc=%h instr=%h v=%b",
                 pc, instr, instr_valid, p_pc, p_instr, p_valid);
      end
    end else begin
      if (p_valid && (p_jb || p_jt || p_jr)) begin
        p4 = p_pc + 32'd4;
        if (p_jr) tgt = p_jrpc & ~32'h3;
        else if (p_jt) tgt = (p4 & 32'hF000_0000) | ((p_instr & 32'h03FF_FFFF) << 2);
        else begin
          off = {{16{p_instr[15]}}, p_instr[15:0]};
          tgt = p4 + (off << 2);
        end
        armed = 1; armed_tgt = tgt;
        if (jmp_at.exists(p_pc)) jmp_at.delete(p_pc);
        else if (force_on && p_jr) force_on = 0;
      end
      if (rq.size() > 0) begin
        w = rq.pop_front();
        checks++;
        if (instr_valid !== 1'b1 || pc !== w.addr || instr !== w.data) begin
          errors++;
          $display("FAIL ifid_load: got pc=%h instr=%h v=%b expected pc=%h instr=%h v=1",
                   pc, instr, instr_valid, w.addr, w.data);
        end
        checks++;
        if (w.addr !== exp_pc) begin
          errors++;
          $display("FAIL fetch_order: got addr=%h expected %h", w.addr, exp_pc);
        end
        dlog.push_back(w.addr);
        exp_pc = armed ? armed_tgt : w.addr + 32'd4;
        armed = 0;
      end else begin
        checks++;
        if (instr_valid !== 1'b0 || instr !== 32'h0 || pc !== p_pc) begin
          errors++;
          $display("FAIL ifid_nop: got pc=%h instr=%h v=%b expected pc=%h instr=0 v=0",
                   pc, instr, instr_valid, p_pc);
        end
      end
    end
    checks++;
    if (imem_req !== (rq.size() == 0)) begin
      errors++;
      $display("FAIL req_state: got imem_req=%b expected %b (skid words=%0d)",
               imem_req, rq.size() == 0, rq.size());
    end
    if (p_req && !p_ack) begin
      checks++;
      if (imem_req !== 1'b1 || imem_addr !== p_addr) begin
        errors++;
        $display("FAIL req_hold: got req=%b addr=%h expected req=1 addr=%h", imem_req, imem_addr, p_addr);
      end
    end
    if (imem_req) begin
      checks++;
      if (imem_addr[1:0] !== 2'b00) begin
        errors++;
        $display("FAIL addr_align: got addr=%h expected low bits 00", imem_addr);
      end
    end
    vlog.push_back(instr_valid);
    if (!p_req || p_ack) begin req_age = 0; cur_lat = $urandom_range(lat_max, lat_min); end
    else req_age++;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 0; imem_ack = 0; imem_rdata = 0; stall = 0;
    jump_branch = 0; jump_target = 0; jump_reg = 0; jr_pc = 0;
    repeat (2) @(negedge clk);
    checks++;
    if (imem_req !== 1'b0 || instr_valid !== 1'b0) begin
      errors++; $display("FAIL reset_ctrl: got req=%b v=%b expected 0 0", imem_req, instr_valid);
    end
    checks++;
    if (pc !== 32'h0 || instr !== 32'h0) begin
      errors++; $display("FAIL reset_ifid: got pc=%h instr=%h expected 0 0", pc, instr);
    end
    rst_n = 1;
    model_reset();
    step();
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== RESET_PC) begin
      errors++; $display("FAIL first_req: got req=%b addr=%h expected 1 %h", imem_req, imem_addr, RESET_PC);
    end
  endtask

  task automatic test_seq();
    dlog.delete();
    repeat (20) step();
    checks++;
    if (dlog.size() != 20) begin
      errors++; $display("FAIL seq_rate: got %0d instrs expected 20", dlog.size());
    end
    for (int i = 0; i < 20 && i < dlog.size(); i++) begin
      checks++;
      if (dlog[i] !== 32'(4 * i)) begin
        errors++; $display("FAIL seq_pc: got %h expected %h", dlog[i], 32'(4 * i));
      end
    end
  endtask

  task automatic test_latency3();
    int s;
    lat_min = 3; lat_max = 3;
    dlog.delete(); vlog.delete();
    repeat (30) step();
    for (int i = 3; i + 2 < vlog.size(); i++) begin
      s = int'(vlog[i]) + int'(vlog[i + 1]) + int'(vlog[i + 2]);
      checks++;
      if (s != 1) begin
        errors++; $display("FAIL lat3_pulse: got %0d valids in window %0d expected 1", s, i);
      end
    end
  endtask

  task automatic test_stall_skid();
    lat_min = 1; lat_max = 1;
    dlog.delete();
    repeat (3) step();
    stall_force = 1;
    step();
    checks++;
    if (imem_req !== 1'b0) begin
      errors++; $display("FAIL skid_wait: got imem_req=%b expected 0", imem_req);
    end
    repeat (3) step();
    stall_force = 0;
    repeat (6) step();
    for (int i = 1; i < dlog.size(); i++) begin
      checks++;
      if (dlog[i] !== dlog[i - 1] + 32'd4) begin
        errors++; $display("FAIL skid_seq: got %h expected %h", dlog[i], dlog[i - 1] + 32'd4);
      end
    end
  endtask

  task automatic test_branch();
    int n = 0, k;
    mem_ovr[32'h100] = 32'h1000_0010;
    jmp_at[32'h100] = '{kind: 2'd1, jr: 32'h0};
    dlog.delete();
    force_jr = 32'h0F8; force_on = 1;
    while (find_pc(32'h144) < 0 && n < 60) begin step(); n++; end
    k = find_pc(32'h100);
    checks++;
    if (k < 0 || k + 2 >= dlog.size() || dlog[k + 1] !== 32'h104 || dlog[k + 2] !== 32'h144) begin
      errors++; $display("FAIL beq_seq: got idx=%0d size=%0d expected 0x100,0x104,0x144", k, dlog.size());
    end
  endtask

  task automatic test_jumps();
    int n = 0, k;
    mem_ovr[32'h200] = 32'h0800_0040;
    jmp_at[32'h200] = '{kind: 2'd2, jr: 32'h0};
    jmp_at[32'h104] = '{kind: 2'd3, jr: 32'h3001};
    lat_min = 1; lat_max = 3; stall_rand = 1;
    dlog.delete();
    force_jr = 32'h1F8; force_on = 1;
    while (find_pc(32'h3000) < 0 && n < 300) begin step(); n++; end
    k = find_pc(32'h200);
    checks++;
    if (k < 0 || k + 5 >= dlog.size()) begin
      errors++; $display("FAIL jump_reach: got idx=%0d size=%0d expected J at 0x200 then 5 more", k, dlog.size());
    end else begin
      checks++;
      if (dlog[k + 1] !== 32'h204 || dlog[k + 2] !== 32'h100) begin
        errors++; $display("FAIL j_seq: got %h,%h expected 204,100", dlog[k + 1], dlog[k + 2]);
      end
      checks++;
      if (dlog[k + 3] !== 32'h104 || dlog[k + 4] !== 32'h108 || dlog[k + 5] !== 32'h3000) begin
        errors++; $display("FAIL jr_seq: got %h,%h,%h expected 104,108,3000", dlog[k + 3], dlog[k + 4], dlog[k + 5]);
      end
    end
    stall_rand = 0;
  endtask

  task automatic test_back_to_back();
    int n = 0, k;
    mem_ovr[32'h404] = 32'h1000_FFF0;
    jmp_at[32'h400] = '{kind: 2'd3, jr: 32'h800};
    jmp_at[32'h404] = '{kind: 2'd1, jr: 32'h0};
    lat_min = 1; lat_max = 2; stall_rand = 1;
    dlog.delete();
    force_jr = 32'h3F8; force_on = 1;
    while (find_pc(32'h3C8) < 0 && n < 200) begin step(); n++; end
    k = find_pc(32'h400);
    checks++;
    if (k < 0 || k + 3 >= dlog.size() || dlog[k + 1] !== 32'h404 || dlog[k + 2] !== 32'h800 || dlog[k + 3] !== 32'h3C8) begin
      errors++; $display("FAIL b2b_seq: got idx=%0d size=%0d expected 400,404,800,3c8", k, dlog.size());
    end
    stall_rand = 0;
  endtask

  task automatic test_wrap();
    int n = 0, k;
    lat_min = 1; lat_max = 1;
    dlog.delete();
    force_jr = 32'hFFFF_FFF0; force_on = 1;
    while (find_pc(32'h4) < 0 && n < 60) begin step(); n++; end
    k = find_pc(32'hFFFF_FFFC);
    checks++;
    if (k < 0 || k + 2 >= dlog.size() || dlog[k + 1] !== 32'h0 || dlog[k + 2] !== 32'h4) begin
      errors++; $display("FAIL wrap_seq: got idx=%0d size=%0d expected fffffffc,0,4", k, dlog.size());
    end
  endtask

  task automatic test_reset_midreq();
    lat_min = 3; lat_max = 3;
    repeat (2) step();
    #2 rst_n = 0;
    #1;
    checks++;
    if (imem_req !== 1'b0 || instr_valid !== 1'b0 || pc !== 32'h0 || instr !== 32'h0) begin
      errors++; $display("FAIL midreset_async: got req=%b v=%b pc=%h instr=%h expected all 0",
                         imem_req, instr_valid, pc, instr);
    end
    imem_ack = 1; imem_rdata = 32'hDEAD_BEEF; stall = 0;
    jump_branch = 0; jump_target = 0; jump_reg = 0;
    @(posedge clk); #1;
    checks++;
    if (imem_req !== 1'b0 || instr_valid !== 1'b0) begin
      errors++; $display("FAIL midreset_hold: got req=%b v=%b expected 0 0", imem_req, instr_valid);
    end
    @(negedge clk);
    rst_n = 1;
    @(posedge clk); #1;
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== RESET_PC || instr_valid !== 1'b0) begin
      errors++; $display("FAIL midreset_restart: got req=%b addr=%h v=%b expected 1 %h 0",
                         imem_req, imem_addr, instr_valid, RESET_PC);
    end
    @(negedge clk);
    lat_min = 1; lat_max = 1;
    model_reset();
    dlog.delete();
    repeat (6) step();
    checks++;
    if (dlog.size() < 2 || dlog[0] !== RESET_PC || dlog[1] !== RESET_PC + 32'd4) begin
      errors++; $display("FAIL midreset_seq: got size=%0d expected first pcs %h,%h", dlog.size(), RESET_PC, RESET_PC + 32'd4);
    end
  endtask

  task automatic test_random();
    lat_min = 1; lat_max = 4;
    stall_rand = 1; rand_jumps = 1; rand_acks = 1;
    repeat (1500) step();
    stall_rand = 0; rand_jumps = 0; rand_acks = 0;
  endtask

  initial begin
    test_reset();
    test_seq();
    test_latency3();
    test_stall_skid();
    test_branch();
    test_jumps();
    test_back_to_back();
    test_wrap();
    test_reset_midreq();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
